slow_clock_monitor: RTL and testbench

- Consumer side of the divided clock: it takes a slow, divided clock (for example the divided ripple clock) back into the fast system clock domain.
- Synchronizes the slow clock and emits single-cycle rise/fall enable ticks in the fast domain.
- Measures the slow-clock period in fast-clock cycles and reports lock and timeout status.
- Lets downstream logic run on `clock` with enables instead of clocking flops from a divided clock.

---
 rtl/slow_clock_monitor_pkg.sv | 16 +
 rtl/bit_synchronizer.sv | 29 ++
 rtl/slow_clock_monitor.sv | 138 +++++++++++++
 tb/tb_slow_clock_monitor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_clock_monitor_pkg.sv
// Shared types and default constants for the slow clock monitor.
package slow_clock_monitor_pkg;

  // Measurement FSM: waiting for a first edge, holding one edge, tracking, locked.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int CNT_WIDTH_DEF      = 20;
  localparam int TIMEOUT_CYCLES_DEF = 1000000;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module bit_synchronizer #(
  parameter int STAGES = 2  // legal range 2..4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops; only the last stage is safe to use downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment makes every stage sample the previous
    // stage's old value, so the chain really is STAGES flops deep.
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/slow_clock_monitor.sv
// Brings a slow/divided clock into the fast domain as rise/fall enable ticks,
// measures its rise-to-rise period and reports lock and timeout status.
module slow_clock_monitor
  import slow_clock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF  // must fit in CNT_WIDTH bits
) (
  input  logic                 clock,
  input  logic                 reset,       // asynchronous, active low
  input  logic                 slow_clock,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic                 s;
  logic                 edge_r;
  logic                 edge_f;
  logic                 timeout_hit;
  logic                 prev_q, prev_d;
  logic                 rise_tick_q, rise_tick_d;
  logic                 fall_tick_q, fall_tick_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 period_valid_q, period_valid_d;
  logic                 timeout_q, timeout_d;
  state_e               state_q, state_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clock),
    .rst_n (reset),
    .d     (slow_clock),
    .q     (s)
  );

  // Edge detect on the synchronized level; ticks are registered from the edges.
  always_comb begin
    prev_d      = s;
    edge_r      = s & ~prev_q;
    edge_f      = ~s & prev_q;
    rise_tick_d = edge_r;
    fall_tick_d = edge_f;
  end

  // Period counter: restarts at 1 on each rise, counts while measuring, saturates.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (edge_r) begin
      cnt_d = CNT_ONE;
    end else if (state_q != IDLE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A rise in the threshold cycle is a normal measurement, never a timeout.
  assign timeout_hit = ~edge_r & (state_q != IDLE) & (cnt_q == TIMEOUT_VAL);

  // Measurement FSM: next state, captured period and status flags.
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    timeout_d      = timeout_q;
    if (timeout_hit) begin
      // Period keeps its last value so software can still read it.
      state_d        = IDLE;
      timeout_d      = 1'b1;
      period_valid_d = 1'b0;
    end else if (edge_r) begin
      timeout_d = 1'b0;
      case (state_q)
        IDLE: begin
          state_d = FIRST;
        end
        FIRST: begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          state_d        = TRACK;
        end
        TRACK: begin
          if (cnt_q == period_q) state_d  = LOCKED;
          else                   period_d = cnt_q;
        end
        LOCKED: begin
          if (cnt_q != period_q) begin
            period_d = cnt_q;
            state_d  = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset drops ticks in flight and clears all status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q         <= 1'b0;
      rise_tick_q    <= 1'b0;
      fall_tick_q    <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      state_q        <= IDLE;
    end else begin
      prev_q         <= prev_d;
      rise_tick_q    <= rise_tick_d;
      fall_tick_q    <= fall_tick_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
      state_q        <= state_d;
    end
  end

  assign rise_tick    = rise_tick_q;
  assign fall_tick    = fall_tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = (state_q == LOCKED);
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Bench for slow_clock_monitor: table-driven phases, hand-written corner
// sequences and random slow-clock patterns, all compared every cycle against
// an event-level model (rise times, measured periods, timeout deadline).
module tb_slow_clock_monitor;

  localparam int SYNC = 2;
  localparam int W    = 8;
  localparam int TOUT = 64;

  logic         clock;
  logic         reset;
  logic         slow_clock;
  logic         rise_tick;
  logic         fall_tick;
  logic [W-1:0] period;
  logic         period_valid;
  logic         locked;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  slow_clock_monitor #(
    .SYNC_STAGES    (SYNC),
    .CNT_WIDTH      (W),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .slow_clock   (slow_clock),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[i] is the level sampled i fast edges ago; a tick appears SYNC edges
  // after the level is first captured.
  logic hist [0:SYNC+1];
  int   cyc;
  bit   sess;        // a rise has been seen since reset/timeout
  int   last_rise;
  int   meas[$];     // periods measured in the current session
  int   m_period;
  bit   m_timeout;
  bit   m_rise;
  bit   m_fall;

  task automatic model_reset();
    for (int i = 0; i <= SYNC + 1; i++) hist[i] = 1'b0;
    cyc = 0; sess = 0; last_rise = 0;
    meas.delete();
    m_period = 0; m_timeout = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic model_step(input logic sc);
    for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sc;
    cyc++;
    m_rise = hist[SYNC] & ~hist[SYNC+1];
    m_fall = ~hist[SYNC] & hist[SYNC+1];
    if (m_rise) begin
      if (sess) begin
        meas.push_back(cyc - last_rise);
        m_period = cyc - last_rise;
        if (meas.size() > 2) void'(meas.pop_front());
      end
      sess = 1; m_timeout = 0; last_rise = cyc;
    end else if (sess && (cyc - last_rise) == TOUT) begin
      sess = 0; m_timeout = 1;
      meas.delete();
    end
  endtask

  function automatic bit m_valid();
    return meas.size() >= 1;
  endfunction

  function automatic bit m_locked();
    if (meas.size() < 2) return 1'b0;
    return meas[meas.size()-1] == meas[meas.size()-2];
  endfunction

  task automatic compare_all();
    check("rise_tick",    rise_tick,    m_rise);
    check("fall_tick",    fall_tick,    m_fall);
    check("period",       period,       m_period);
    check("period_valid", period_valid, m_valid());
    check("locked",       locked,       m_locked());
    check("timeout",      timeout,      m_timeout);
  endtask

  // One fast cycle: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input logic sc);
    slow_clock = sc;
    @(posedge clock);
    model_step(sc);
    @(negedge clock);
    compare_all();
  endtask

  // ---------------- slow clock generator ----------------
  logic gen_level;
  int   gen_cnt;

  function automatic logic gen_next(input int half, input logic hold);
    logic v;
    if (half == 0) begin
      gen_level = hold;
      return hold;
    end
    v = gen_level;
    gen_cnt++;
    if (gen_cnt >= half) begin
      gen_level = ~gen_level;
      gen_cnt   = 0;
    end
    return v;
  endfunction

  // ---------------- phase table ----------------
  typedef struct {
    int   half;        // 0 = hold slow_clock at 'hold'
    logic hold;
    int   cycles;
    int   exp_period;
    logic exp_valid;
    logic exp_locked;
    logic exp_timeout;
  } row_t;

  row_t rows [8];

  int n;
  int nrise;

  initial begin
    rows[0] = '{8,  1'b0, 120, 16, 1'b1, 1'b1, 1'b0};
    rows[1] = '{5,  1'b0,  80, 10, 1'b1, 1'b1, 1'b0};
    rows[2] = '{1,  1'b0,  40,  2, 1'b1, 1'b1, 1'b0};  // minimum period
    rows[3] = '{0,  1'b1,  80,  2, 1'b0, 1'b0, 1'b1};  // held high: no ticks, timeout
    rows[4] = '{32, 1'b0, 400, 64, 1'b1, 1'b1, 1'b0};  // rise exactly at threshold
    rows[5] = '{3,  1'b0,  60,  6, 1'b1, 1'b1, 1'b0};
    rows[6] = '{8,  1'b0, 120, 16, 1'b1, 1'b1, 1'b0};
    rows[7] = '{0,  1'b0,  80, 16, 1'b0, 1'b0, 1'b1};  // held low: timeout

    reset      = 1'b0;
    slow_clock = 1'b0;
    gen_level  = 1'b0;
    gen_cnt    = 0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();                      // reset values
    reset = 1'b1;

    // First rise latency from the first captured high.
    repeat (3) cycle(1'b0);
    gen_level = 1'b1; gen_cnt = 0;
    n = 0;
    while (n < 10) begin
      cycle(gen_next(8, 1'b0));
      n++;
      if (rise_tick) break;
    end
    check("first_tick_latency", n, SYNC + 1);

    // Period valid on the second rise, locked on the third.
    nrise = 1; n = 0;
    while (nrise < 3 && n < 60) begin
      cycle(gen_next(8, 1'b0));
      n++;
      if (rise_tick) begin
        nrise++;
        if (nrise == 2) begin
          check("rise2_period", period, 16);
          check("rise2_valid",  period_valid, 1);
          check("rise2_locked", locked, 0);
        end else begin
          check("rise3_locked", locked, 1);
        end
      end
    end
    check("lock16_reached", nrise, 3);

    // Retune to a 10-cycle period: first rise unlocks, next relocks.
    nrise = 0; n = 0;
    while (nrise < 2 && n < 60) begin
      cycle(gen_next(5, 1'b0));
      n++;
      if (rise_tick) begin
        nrise++;
        check($sformatf("retune_rise%0d_period", nrise), period, 10);
        check($sformatf("retune_rise%0d_locked", nrise), locked, nrise == 2);
      end
    end
    check("retune_rises", nrise, 2);

    // Table-driven phases.
    for (int r = 0; r < 8; r++) begin
      gen_cnt = 0;
      for (int c = 0; c < rows[r].cycles; c++) cycle(gen_next(rows[r].half, rows[r].hold));
      check($sformatf("row%0d_period",  r), period,       rows[r].exp_period);
      check($sformatf("row%0d_valid",   r), period_valid, rows[r].exp_valid);
      check($sformatf("row%0d_locked",  r), locked,       rows[r].exp_locked);
      check($sformatf("row%0d_timeout", r), timeout,      rows[r].exp_timeout);
    end

    // Recovery after timeout: first rise clears timeout and only arms a measurement.
    gen_level = 1'b0; gen_cnt = 0;
    nrise = 0; n = 0;
    while (nrise < 2 && n < 80) begin
      cycle(gen_next(8, 1'b0));
      n++;
      if (rise_tick) begin
        nrise++;
        if (nrise == 1) begin
          check("recover_timeout", timeout, 0);
          check("recover_valid",   period_valid, 0);
          check("recover_period",  period, 16);
        end else begin
          check("recover2_valid",  period_valid, 1);
          check("recover2_period", period, 16);
        end
      end
    end
    check("recover_rises", nrise, 2);

    // Lock, then pulse reset asynchronously and re-lock.
    n = 0;
    while (!locked && n < 100) begin
      cycle(gen_next(8, 1'b0));
      n++;
    end
    check("prelock", locked, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_rise_tick",    rise_tick, 0);
    check("rst_fall_tick",    fall_tick, 0);
    check("rst_period",       period, 0);
    check("rst_period_valid", period_valid, 0);
    check("rst_locked",       locked, 0);
    check("rst_timeout",      timeout, 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    gen_level = 1'b0; gen_cnt = 0;
    nrise = 0; n = 0;
    while (!locked && n < 100) begin
      cycle(gen_next(8, 1'b0));
      n++;
      if (rise_tick) nrise++;
    end
    check("relock_rises", nrise, 3);

    // Random periods and holds.
    for (int seg = 0; seg < 14; seg++) begin
      int half;
      int len;
      logic hold;
      half = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      hold = logic'($urandom_range(1, 0));
      len  = int'($urandom_range(120, 20));
      gen_cnt = 0;
      for (int c = 0; c < len; c++) cycle(gen_next(half, hold));
    end

    // Random per-cycle levels: never more than one tick per transition.
    for (int c = 0; c < 300; c++) cycle(logic'($urandom_range(1, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
